// File: rtl/mips_cpu_muldiv_pkg.sv
// ============================================================================
// Module   : mips_cpu_muldiv_pkg
// Purpose  : Shared types and helpers for the iterative MIPS mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_cpu_muldiv_pkg;

    localparam int ABS_MAXW = 64;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    // Two's-complement negate when neg is set; callers zero-extend and
    // keep only their own width, so the result is correct modulo 2^WIDTH.
    function automatic logic [ABS_MAXW-1:0] abs_val(input logic [ABS_MAXW-1:0] v,
                                                    input logic                neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_cpu_muldiv_step.sv
// ============================================================================
// Module   : mips_cpu_muldiv_step
// Purpose  : One radix-2 step: shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_muldiv_step
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  step_mode_t         i_mode,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_mul_sum;
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                     + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});

    // Divide: acc = {partial remainder, dividend bits becoming quotient}.
    assign w_div_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, i_operand};

    always_comb begin
        o_acc = i_acc;
        if (i_mode == STEP_MUL) begin
            o_acc = {w_mul_sum, i_acc[WIDTH-1:1]};
        end else if (!w_div_diff[WIDTH]) begin
            o_acc = {w_div_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_div_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
// ============================================================================
// Module   : mips_cpu_muldiv
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    step_mode_t         r_mode;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    muldiv_op_t            w_op;
    logic                  w_signed;
    logic [ABS_MAXW-1:0]   w_abs_a_full;
    logic [ABS_MAXW-1:0]   w_abs_b_full;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic                  w_unused_abs;
    logic [2*WIDTH-1:0]    w_step_acc;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH-1:0]      w_fix_hi;
    logic [WIDTH-1:0]      w_fix_lo;

    assign w_op     = muldiv_op_t'(op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

    assign w_abs_a_full = abs_val(ABS_MAXW'(a), w_signed & a[WIDTH-1]);
    assign w_abs_b_full = abs_val(ABS_MAXW'(b), w_signed & b[WIDTH-1]);
    assign w_abs_a      = w_abs_a_full[WIDTH-1:0];
    assign w_abs_b      = w_abs_b_full[WIDTH-1:0];
    assign w_unused_abs = ^{w_abs_a_full, w_abs_b_full};

    mips_cpu_muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_mode    (r_mode),
        .o_acc     (w_step_acc)
    );

    // Sign correction; most-negative / -1 falls out naturally as 0x80..0.
    assign w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_mode == STEP_DIV) begin
            if (r_div_zero) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_lo = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
                w_fix_hi = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                    : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_mode     <= STEP_MUL;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (w_op)
                            OP_MULT, OP_MULTU: begin
                                r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
                                r_operand <= w_abs_a;
                                r_mode    <= STEP_MUL;
                                r_neg_lo  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_hi  <= 1'b0;
                                r_cnt     <= CNT_W'(WIDTH - 1);
                                r_state   <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_acc      <= {{WIDTH{1'b0}}, w_abs_a};
                                r_operand  <= w_abs_b;
                                r_mode     <= STEP_DIV;
                                r_neg_lo   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_hi   <= w_signed & a[WIDTH-1];
                                r_div_zero <= (b == '0);
                                r_a_raw    <= a;
                                r_cnt      <= CNT_W'(WIDTH - 1);
                                r_state    <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// ============================================================================
// Module   : tb_mips_cpu_muldiv
// Purpose  : Directed self-checking bench for the iterative mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_muldiv;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    mips_cpu_muldiv #(
        .WIDTH    (WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    // Counts busy cycles until completion, then checks result and done pulse.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int n;
        issue(o, va, vb);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(WIDTH + 1));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        check({tag, " done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",      3'd4, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_zero", 3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

        // MTHI while idle
        issue(3'd5, 32'h1234, 32'd0);
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);

        // Code 7 is a NOP
        issue(3'd7, 32'hDEAD_BEEF, 32'd3);
        check("op7 busy", 64'(busy), 64'd0);
        check("op7 hi", 64'(hi), 64'h1234);
        check("op7 lo", 64'(lo), 64'h8000_0000);

        // MTLO presented while a MULTU runs must be dropped
        issue(3'd2, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        check("mtlo_busy lo", 64'(lo), 64'h8000_0000);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("mtlo_busy done", 64'(done), 64'd1);
        check("mtlo_busy hi", 64'(hi), 64'd0);
        check("mtlo_busy lo_final", 64'(lo), 64'd6);

        // Reset in the middle of a MULT aborts it
        issue(3'd1, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check("abort no_done", 64'(n), 64'd0);

        run_op("divu_after", 3'd4, 32'd9, 32'd3, 32'd0, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
